// File: rtl/k2_pkg.sv
// k2_pkg: K2 instruction format, opcode classes and the default program image
// shared by the fetch/decode block and its instruction memory.
package k2_pkg;

    localparam int K2_DEPTH = 9;
    localparam int K2_IW    = 8;

    typedef struct packed {
        logic       jcls;         // 1: jump class
        logic       cond_or_add;  // jump class: 1=JC, 0=JMP; otherwise 1=ADD
        logic [2:0] rsv;
        logic [2:0] imm;          // jump target
    } instr_t;

    // Opcode class = {jcls, cond_or_add}; OP_NOP also covers MOV/OUT.
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_JMP = 2'b10;
    localparam logic [1:0] OP_JC  = 2'b11;

    typedef logic [K2_IW-1:0] prog_t [K2_DEPTH];

    localparam prog_t K2_DEFAULT_PROG = '{
        8'h00,  // 0: NOP
        8'h41,  // 1: ADD
        8'hC2,  // 2: JC  2
        8'h85,  // 3: JMP 5
        8'h12,  // 4: MOV
        8'h47,  // 5: ADD
        8'hC0,  // 6: JC  0
        8'h23,  // 7: OUT
        8'h83   // 8: JMP 3
    };

    function automatic logic [K2_IW-1:0] default_word(input int unsigned idx);
        return (idx < K2_DEPTH) ? K2_DEFAULT_PROG[idx] : '0;
    endfunction

endpackage

// File: rtl/k2_imem.sv
// k2_imem: K2 instruction memory with out-of-range NOP read mux.
// Build option: K2_PROG_LOAD_EN turns the constant ROM into a writable RAM.
module k2_imem
    import k2_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = K2_DEPTH,
    parameter int IW    = K2_IW
)(
`ifdef K2_PROG_LOAD_EN
    input  logic                     clk,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [IW-1:0]            prog_data,
`endif
    input  logic [N-1:0]             pc,
    output logic [IW-1:0]            rdata
);

    localparam int AW = $clog2(DEPTH);

`ifdef K2_PROG_LOAD_EN
    // NOTE: the program RAM has no reset; it powers up holding the default
    // image and keeps its contents across reset.
    logic [IW-1:0] mem [DEPTH] = K2_DEFAULT_PROG;

    always_ff @(posedge clk) begin
        if (prog_we && (prog_addr < AW'(DEPTH))) begin
            mem[prog_addr] <= prog_data;
        end
    end
`else
    logic [IW-1:0] mem [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign mem[i] = IW'(default_word(i));
    end
`endif

    // Addresses past the end of the program read as NOP.
    assign rdata = (pc < N'(DEPTH)) ? mem[pc[AW-1:0]] : '0;

endmodule

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: fetches the word at pc, decodes jump control back to the PC,
// and holds the carry flag and datapath instruction register. Option: K2_PROG_LOAD_EN.
module instr_fetch_decode
    import k2_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = K2_DEPTH,
    parameter int IW    = K2_IW
)(
    input  logic                     clk,
    input  logic                     reset,
`ifdef K2_PROG_LOAD_EN
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [IW-1:0]            prog_data,
`endif
    input  logic [N-1:0]             pc,
    input  logic                     alu_carry,
    output logic [IW-1:0]            instr,
    output logic                     jump,
    output logic [2:0]               jump_imm,
    output logic [IW-1:0]            ir,
    output logic                     ir_valid,
    output logic                     cflag
);

    logic [IW-1:0] rdata;
    instr_t        word;
    logic [1:0]    op;
    logic          cflag_next;

    k2_imem #(.N(N), .DEPTH(DEPTH), .IW(IW)) u_imem (
`ifdef K2_PROG_LOAD_EN
        .clk       (clk),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
`endif
        .pc        (pc),
        .rdata     (rdata)
    );

    assign word     = rdata;
    assign instr    = word;
    assign op       = {word.jcls, word.cond_or_add};
    assign jump     = (op == OP_JMP) || ((op == OP_JC) && cflag);
    assign jump_imm = word.imm;

    // NOTE: default assigned first so every path drives cflag_next (no latch).
    always_comb begin
        cflag_next = cflag;
        case (op)
            OP_JC:          cflag_next = 1'b0;  // taken JC consumes it; untaken JC already 0
            OP_ADD:         cflag_next = alu_carry;
            OP_JMP, OP_NOP: cflag_next = cflag;
            default:        cflag_next = cflag;
        endcase
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir       <= '0;
            ir_valid <= 1'b0;
            cflag    <= 1'b0;
        end else begin
            ir       <= word;
            ir_valid <= 1'b1;
            cflag    <= cflag_next;
        end
    end

endmodule
